// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave, and the grant is held for the whole master cycle.
// Define WB_RR_ARB_TIMEOUT_EN to add a watchdog that aborts a hung slave access with an error response.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
  output logic [32*NUM_MASTERS-1:0] wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [31:0]               wbs_adr_o,
  output logic [31:0]               wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [31:0]               wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("wb_rr_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1
`ifdef WB_RR_ARB_TIMEOUT_EN
    ,
    ABORT   = 2'd2
`endif
  } state_t;

  state_t            state, state_d;
  logic [IDX_W-1:0]  gnt_idx, last_idx;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [IDX_W:0]    cand;
  logic              timeout;
  logic              pass;

  logic [31:0] adr_sel, dat_sel;
  logic [3:0]  sel_sel;
  logic [2:0]  cti_sel;
  logic [1:0]  bte_sel;
  logic        we_sel, cyc_sel, stb_sel;

  // Rotating scan starting just after the last master served.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_idx;
    cand       = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = {1'b0, last_idx} + (IDX_W+1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!pick_valid && wbm_cyc_i[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    adr_sel = '0;
    dat_sel = '0;
    sel_sel = '0;
    cti_sel = '0;
    bte_sel = '0;
    we_sel  = 1'b0;
    cyc_sel = 1'b0;
    stb_sel = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        adr_sel = wbm_adr_i[i*32 +: 32];
        dat_sel = wbm_dat_i[i*32 +: 32];
        sel_sel = wbm_sel_i[i*4 +: 4];
        cti_sel = wbm_cti_i[i*3 +: 3];
        bte_sel = wbm_bte_i[i*2 +: 2];
        we_sel  = wbm_we_i[i];
        cyc_sel = wbm_cyc_i[i];
        stb_sel = wbm_stb_i[i];
      end
    end
  end

`ifdef WB_RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stall_cnt <= '0;
    end else if (state != GRANTED || !wbs_stb_o || wbs_ack_i || wbs_err_i || wbs_rty_i) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign timeout = (state == GRANTED) && cyc_sel && (stall_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      last_idx <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state <= state_d;
      if (state == IDLE && pick_valid) gnt_idx <= pick_idx;
      if (state != IDLE && state_d == IDLE) last_idx <= gnt_idx;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pick_valid) state_d = GRANTED;
      GRANTED: begin
        if (!cyc_sel) state_d = IDLE;
`ifdef WB_RR_ARB_TIMEOUT_EN
        else if (timeout) state_d = ABORT;
      end
      ABORT: begin
        if (!cyc_sel) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // The slave only ever sees the granted master, and nothing while idle or aborting.
  assign pass = (state == GRANTED) && !timeout;

  always_comb begin
    wbs_adr_o = pass ? adr_sel : '0;
    wbs_dat_o = pass ? dat_sel : '0;
    wbs_sel_o = pass ? sel_sel : '0;
    wbs_cti_o = pass ? cti_sel : '0;
    wbs_bte_o = pass ? bte_sel : '0;
    wbs_we_o  = pass && we_sel;
    wbs_cyc_o = pass && cyc_sel;
    wbs_stb_o = pass && stb_sel;
    wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    grant_o   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        wbm_ack_o[i] = pass && wbs_ack_i;
        wbm_err_o[i] = (pass && wbs_err_i) || timeout;
        wbm_rty_o[i] = pass && wbs_rty_i;
        grant_o[i]   = (state != IDLE);
      end
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with two masters: a per-cycle vector table for arbitration and
// hand-written sequences for datapath, bursts, reset mid-burst and the hung-slave case.
module tb_wb_rr_arbiter;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   wbm_adr_i, wbm_dat_i;
  logic [7:0]    wbm_sel_i;
  logic [1:0]    wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [5:0]    wbm_cti_i;
  logic [3:0]    wbm_bte_i;
  logic [63:0]   wbm_dat_o;
  logic [1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0]   wbs_adr_o, wbs_dat_o;
  logic [3:0]    wbs_sel_o;
  logic          wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]    wbs_cti_o;
  logic [1:0]    wbs_bte_o;
  logic [31:0]   wbs_dat_i;
  logic          wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic [1:0]    grant_o;

  int checks = 0;
  int errors = 0;

  wb_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i (wbm_we_i),  .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o (wbs_we_o),  .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .grant_o  (grant_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic       rst;
    logic [1:0] cyc, stb;
    logic       ack, err, rty;
    logic [1:0] e_gnt;
    logic       e_cyc, e_stb;
    logic [1:0] e_ack, e_err, e_rty;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [1:0] c, input logic [1:0] s,
                              input logic a, input logic e, input logic y,
                              input logic [1:0] g, input logic sc, input logic ss,
                              input logic [1:0] ea, input logic [1:0] ee, input logic [1:0] ey);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.ack = a; v.err = e; v.rty = y;
    v.e_gnt = g; v.e_cyc = sc; v.e_stb = ss; v.e_ack = ea; v.e_err = ee; v.e_rty = ey;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, outputs checked #1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic [1:0] g, input logic sc, input logic ss,
                           input logic [1:0] ea, input logic [1:0] ee);
    check({tag, " grant"}, 64'(grant_o), 64'(g));
    check({tag, " wbs_cyc"}, 64'(wbs_cyc_o), 64'(sc));
    check({tag, " wbs_stb"}, 64'(wbs_stb_o), 64'(ss));
    check({tag, " ack"}, 64'(wbm_ack_o), 64'(ea));
    check({tag, " err"}, 64'(wbm_err_o), 64'(ee));
  endtask

  initial begin
    rst = 1'b1;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = '0;
    wbm_cyc_i = '0; wbm_stb_i = '0; wbm_cti_i = '0; wbm_bte_i = '0;
    wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;

    //            rst  cyc    stb    ack  err  rty | gnt   scyc sstb ack_o  err_o  rty_o
    // Single m0 access after reset, 1-cycle grant latency.
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0, 2'b01, 1, 1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0, 2'b01, 1, 1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 2'b01, 1, 1, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00));
    // Reset, then simultaneous m0/m1: m0 first, m1 after one idle cycle.
    vecs.push_back(mk(1, 2'b11, 2'b11, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0, 2'b01, 1, 1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b11, 2'b11, 1, 0, 0, 2'b01, 1, 1, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b10, 2'b10, 0, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b10, 2'b10, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b10, 2'b10, 0, 0, 0, 2'b10, 1, 1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b10, 2'b10, 1, 0, 0, 2'b10, 1, 1, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00));
    // Both re-request: rotation gives m0; m0 re-requesting at once loses to m1.
    vecs.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0, 2'b01, 1, 1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b10, 2'b10, 0, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b11, 2'b11, 0, 0, 1, 2'b10, 1, 1, 2'b00, 2'b00, 2'b10));
    // Slave error on m1 goes to m1 only; then m0 with stb low, then idle.
    vecs.push_back(mk(0, 2'b11, 2'b11, 0, 1, 0, 2'b10, 1, 1, 2'b00, 2'b10, 2'b00));
    vecs.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b01, 2'b00, 0, 0, 0, 2'b01, 1, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00));

    repeat (2) @(posedge clk);
    settle();
    check("reset grant", 64'(grant_o), 64'(2'b00));
    check("reset wbs_cyc", 64'(wbs_cyc_o), 64'(1'b0));
    check("reset wbs_adr", 64'(wbs_adr_o), 64'h0);
    check("reset acks", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step();
      rst = vecs[i].rst;
      wbm_cyc_i = vecs[i].cyc;
      wbm_stb_i = vecs[i].stb;
      wbs_ack_i = vecs[i].ack;
      wbs_err_i = vecs[i].err;
      wbs_rty_i = vecs[i].rty;
      settle();
      check_ctl($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_cyc, vecs[i].e_stb,
                vecs[i].e_ack, vecs[i].e_err);
      check($sformatf("vec%0d rty", i), 64'(wbm_rty_o), 64'(vecs[i].e_rty));
    end

    // Datapath: m0 read of 0x90000004; m1 drives different values that must not leak.
    step();
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    wbm_adr_i = {32'h2000_0000, 32'h9000_0004};
    wbm_dat_i = {32'hDEAD_BEEF, 32'h1234_5678};
    wbm_sel_i = {4'h3, 4'hF};
    wbm_we_i  = 2'b10;
    wbm_cti_i = {3'b001, 3'b000};
    wbm_bte_i = {2'b11, 2'b00};
    wbm_cyc_i = 2'b01; wbm_stb_i = 2'b01;
    settle();
    check("dp idle adr", 64'(wbs_adr_o), 64'h0);
    step(); settle();
    check("dp grant", 64'(grant_o), 64'(2'b01));
    check("dp adr", 64'(wbs_adr_o), 64'h9000_0004);
    check("dp dat", 64'(wbs_dat_o), 64'h1234_5678);
    check("dp sel", 64'(wbs_sel_o), 64'hF);
    check("dp we", 64'(wbs_we_o), 64'h0);
    check("dp bte", 64'(wbs_bte_o), 64'h0);
    step(); settle();
    check("dp wait ack", 64'(wbm_ack_o), 64'(2'b00));
    step();
    wbs_dat_i = 32'hA5A5_A5A5; wbs_ack_i = 1'b1;
    settle();
    check("dp ack", 64'(wbm_ack_o), 64'(2'b01));
    check("dp rdata", wbm_dat_o, {2{32'hA5A5_A5A5}});
    step();
    wbs_ack_i = 1'b0; wbm_cyc_i = 2'b00; wbm_stb_i = 2'b00;
    settle();
    check("dp end cyc", 64'(wbs_cyc_o), 64'h0);

    // m1 4-beat incrementing burst while m0 waits; m0 only after the burst.
    step();
    wbm_cyc_i = 2'b11; wbm_stb_i = 2'b11;
    wbm_cti_i = {3'b010, 3'b000}; wbm_bte_i = 2'b00;
    wbm_adr_i = {32'h0000_1000, 32'h9000_0000};
    settle();
    check("burst idle", 64'(grant_o), 64'(2'b00));
    for (int b = 0; b < 4; b++) begin
      step();
      wbm_adr_i[63:32] = 32'h0000_1000 + 32'(4 * b);
      wbm_cti_i[5:3]   = (b == 3) ? 3'b111 : 3'b010;
      wbs_ack_i = 1'b1;
      settle();
      check($sformatf("burst b%0d grant", b), 64'(grant_o), 64'(2'b10));
      check($sformatf("burst b%0d adr", b), 64'(wbs_adr_o), 64'(32'h0000_1000 + 32'(4 * b)));
      check($sformatf("burst b%0d cti", b), 64'(wbs_cti_o), 64'((b == 3) ? 3'b111 : 3'b010));
      check($sformatf("burst b%0d ack", b), 64'(wbm_ack_o), 64'(2'b10));
    end
    step();
    wbs_ack_i = 1'b0; wbm_cyc_i = 2'b01; wbm_stb_i = 2'b01;
    settle();
    check_ctl("burst end", 2'b10, 1'b0, 1'b0, 2'b00, 2'b00);
    step(); settle();
    check("burst gap", 64'(grant_o), 64'(2'b00));
    step(); settle();
    check_ctl("burst m0 next", 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
    step();
    wbm_cyc_i = 2'b00; wbm_stb_i = 2'b00;
    step();

    // Reset during beat 2 of an m1 burst; m0 wins first afterwards.
    wbm_cyc_i = 2'b10; wbm_stb_i = 2'b10; wbm_cti_i = {3'b010, 3'b000};
    step();
    wbs_ack_i = 1'b1;
    settle();
    check_ctl("rstb beat1", 2'b10, 1'b1, 1'b1, 2'b10, 2'b00);
    step();
    rst = 1'b1; wbm_cyc_i = 2'b11; wbm_stb_i = 2'b11;
    settle();
    check("rstb beat2 grant", 64'(grant_o), 64'(2'b10));
    step();
    rst = 1'b0; wbs_ack_i = 1'b0;
    settle();
    check_ctl("rstb after", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    step(); settle();
    check_ctl("rstb m0 first", 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
    step();
    wbm_cyc_i = 2'b00; wbm_stb_i = 2'b00;
    step();

    // Hung slave: m0 strobes and nobody answers.
    wbm_cyc_i = 2'b01; wbm_stb_i = 2'b01;
`ifdef WB_RR_ARB_TIMEOUT_EN
    for (int j = 0; j < 16; j++) begin
      step(); settle();
      check_ctl($sformatf("hang c%0d", j), 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
    end
    step(); settle();
    check_ctl("timeout pulse", 2'b01, 1'b0, 1'b0, 2'b00, 2'b01);
    step();
    wbs_ack_i = 1'b1;
    settle();
    check_ctl("abort stray ack", 2'b01, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    wbs_ack_i = 1'b0; wbm_cyc_i = 2'b00; wbm_stb_i = 2'b00;
    settle();
    check("abort cyc", 64'(wbs_cyc_o), 64'h0);
    step(); settle();
    check("abort exit", 64'(grant_o), 64'(2'b00));
`else
    for (int j = 0; j < 20; j++) begin
      step(); settle();
      check_ctl($sformatf("hang c%0d", j), 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
    end
    step();
    wbm_cyc_i = 2'b00; wbm_stb_i = 2'b00;
    step(); settle();
    check("hang exit", 64'(grant_o), 64'(2'b00));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
